// File: rtl/bit_scan_unit_if.sv
// Request/response bundle for bit_scan_unit.
// The master side is the issuing pipeline and the slave side is the scan unit.
interface bit_scan_unit_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned RES_W = $clog2(XLEN + 1);

  logic             req_valid_in;
  logic             req_ready_out;
  logic [1:0]       req_op_in;
  logic [XLEN-1:0]  req_opnd_in;
  logic             kill_in;
  logic             rsp_valid_out;
  logic             rsp_ready_in;
  logic [RES_W-1:0] rsp_result_out;

  modport master (
    output req_valid_in, req_op_in, req_opnd_in, kill_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_result_out
  );

  modport slave (
    input  req_valid_in, req_op_in, req_opnd_in, kill_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_result_out
  );
endinterface

// File: rtl/bit_scan_unit.sv
// Multi-cycle bit-scan unit: SIZE / CLZ / CTZ / CPOP on an XLEN operand,
// STEP_BITS bits per cycle, LSB first.
// Optional feature macro: BSU_EARLY_EXIT_EN (finish the scan as soon as the
// remaining unscanned bits are all zero).
module bit_scan_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 4
) (
  input logic            clk_in,
  input logic            reset_in,
  bit_scan_unit_if.slave bus
);
  localparam int unsigned RES_W   = $clog2(XLEN + 1);
  localparam int unsigned N_STEPS = XLEN / STEP_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SIZE = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CTZ  = 2'b10;

  if ((XLEN % STEP_BITS) != 0) begin : g_bad_step
    $error("bit_scan_unit: XLEN must be a multiple of STEP_BITS");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [XLEN-1:0]  r_shift;
  logic [XLEN-1:0]  w_shift_nxt;
  logic [1:0]       r_op;
  logic [RES_W-1:0] r_idx;
  logic [RES_W-1:0] r_cnt;
  logic [RES_W-1:0] r_pop;
  logic [RES_W-1:0] r_last;
  logic [RES_W-1:0] r_first;
  logic             r_first_vld;
  logic [RES_W-1:0] w_pop;
  logic [RES_W-1:0] w_last;
  logic [RES_W-1:0] w_first;
  logic             w_first_vld;
  logic [RES_W-1:0] w_result;
  logic [RES_W-1:0] r_result;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             w_accept;
  logic             w_scan_end;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid_in && !bus.kill_in;
  assign w_shift_nxt = r_shift >> STEP_BITS;

`ifdef BSU_EARLY_EXIT_EN
  // Nothing left to find once the unscanned remainder is zero.
  assign w_scan_end = (r_cnt == RES_W'(N_STEPS - 1)) || (w_shift_nxt == '0);
`else
  assign w_scan_end = (r_cnt == RES_W'(N_STEPS - 1));
`endif

  // State register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; kill beats every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.kill_in) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_SCAN;
        S_SCAN:  if (w_scan_end) w_state_nxt = S_DONE;
        S_DONE:  if (bus.rsp_ready_in) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Fold the low STEP_BITS of the shift register into the running statistics.
  always_comb begin
    w_pop       = r_pop;
    w_last      = r_last;
    w_first     = r_first;
    w_first_vld = r_first_vld;
    for (int unsigned j = 0; j < STEP_BITS; j++) begin
      if (r_shift[j]) begin
        w_pop  = w_pop + RES_W'(1);
        w_last = r_idx + RES_W'(j + 1);
        if (!w_first_vld) begin
          w_first     = r_idx + RES_W'(j);
          w_first_vld = 1'b1;
        end
      end
    end
  end

  // Select the final answer from the statistics including the current step.
  always_comb begin
    w_result = w_pop;
    case (r_op)
      OP_SIZE: w_result = (w_last == '0) ? RES_W'(1) : w_last;
      OP_CLZ:  w_result = RES_W'(XLEN) - w_last;
      OP_CTZ:  w_result = w_first_vld ? w_first : RES_W'(XLEN);
      default: w_result = w_pop;
    endcase
  end

  // Datapath: load on accept, accumulate during SCAN, capture result on the last step.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_shift     <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pop       <= '0;
      r_last      <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
      r_result    <= '0;
    end else if (w_accept) begin
      r_shift     <= bus.req_opnd_in;
      r_op        <= bus.req_op_in;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pop       <= '0;
      r_last      <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end else if (r_state == S_SCAN) begin
      r_shift     <= w_shift_nxt;
      r_idx       <= r_idx + RES_W'(STEP_BITS);
      r_cnt       <= r_cnt + RES_W'(1);
      r_pop       <= w_pop;
      r_last      <= w_last;
      r_first     <= w_first;
      r_first_vld <= w_first_vld;
      if (w_scan_end && !bus.kill_in) begin
        r_result <= w_result;
      end
    end
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.req_ready_out  = r_req_ready;
  assign bus.rsp_valid_out  = r_rsp_valid;
  assign bus.rsp_result_out = r_result;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Scoreboard bench for bit_scan_unit: the driver pushes expected results and
// latencies, an independent monitor pops and compares on each response handshake.
module tb_bit_scan_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEP  = 4;
  localparam int unsigned NST   = XLEN / STEP;

  typedef struct {
    logic [5:0] res;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t exp_q[$];
  bit   rand_bp  = 1'b0;

  bit_scan_unit_if #(.XLEN(XLEN)) bus();

  bit_scan_unit #(.XLEN(XLEN), .STEP_BITS(STEP)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter used to measure accept-to-valid latency.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [5:0] ref_res(input logic [1:0] op, input logic [31:0] v);
    int msb = -1;
    int lsb = -1;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        msb = i;
        if (lsb < 0) lsb = i;
      end
    end
    case (op)
      2'b00:   return (msb < 0) ? 6'd1 : 6'(msb + 1);
      2'b01:   return 6'(31 - msb);
      2'b10:   return (lsb < 0) ? 6'd32 : 6'(lsb);
      default: return 6'($countones(v));
    endcase
  endfunction

  // Clock edges from the accepting edge to the edge that raises rsp_valid_out.
  function automatic int ref_lat(input logic [31:0] v);
`ifdef BSU_EARLY_EXIT_EN
    int bits = 0;
    int k;
    for (int i = 0; i < 32; i++) if (v[i]) bits = i + 1;
    k = (bits + int'(STEP) - 1) / int'(STEP);
    return (k < 1) ? 1 : k;
`else
    return int'(NST);
`endif
  endfunction

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  // Present a request and return the index of the edge that accepted it.
  task automatic issue(input logic [1:0] op, input logic [31:0] opnd, output int acc, output bit ok);
    int n = 0;
    bus.req_op_in    = op;
    bus.req_opnd_in  = opnd;
    bus.req_valid_in = 1'b1;
    while (!bus.req_ready_out && n < 50) begin
      step();
      n++;
    end
    ok = (n < 50);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: req_ready_out stuck at 0");
    end
    step();
    acc = cyc;
    bus.req_valid_in = 1'b0;
    bus.req_op_in    = 2'($urandom_range(0, 3));
    bus.req_opnd_in  = $urandom();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      bus.rsp_ready_in = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      n++;
    end
    bus.rsp_ready_in = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] opnd, input string nm);
    exp_t e;
    int   acc;
    bit   ok;
    issue(op, opnd, acc, ok);
    if (!ok) return;
    e.acc  = acc;
    e.res  = ref_res(op, opnd);
    e.lat  = ref_lat(opnd);
    e.name = nm;
    exp_q.push_back(e);
    wait_drain();
  endtask

  // Monitor: stability while held, handshake compare, ready returns after handshake.
  int         vstart    = -1;
  logic [5:0] prev_res  = '0;
  bit         ready_chk = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (reset_in) begin
      vstart    = -1;
      ready_chk = 1'b0;
    end else begin
      if (ready_chk) begin
        chk("ready_after_rsp", 32'(bus.req_ready_out), 32'd1);
        ready_chk = 1'b0;
      end
      if (bus.rsp_valid_out) begin
        if (vstart < 0) begin
          vstart   = cyc;
          prev_res = bus.rsp_result_out;
        end else begin
          chk("result_stable", 32'(bus.rsp_result_out), 32'(prev_res));
        end
        chk("ready_low_in_done", 32'(bus.req_ready_out), 32'd0);
        if (bus.rsp_ready_in && !bus.kill_in) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_rsp: result %0d with nothing outstanding", bus.rsp_result_out);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, " result"}, 32'(bus.rsp_result_out), 32'(e.res));
            chk({e.name, " latency"}, 32'(vstart - e.acc), 32'(e.lat));
          end
          vstart    = -1;
          ready_chk = 1'b1;
        end
      end else begin
        vstart = -1;
      end
    end
  end

  initial begin
    int   acc;
    bit   ok;
    int   n;
    exp_t e;
    bus.req_valid_in = 1'b0;
    bus.req_op_in    = 2'b00;
    bus.req_opnd_in  = '0;
    bus.kill_in      = 1'b0;
    bus.rsp_ready_in = 1'b0;
    #1 reset_in = 1'b1;
    repeat (3) step();
    chk("reset_ready", 32'(bus.req_ready_out), 32'd1);
    chk("reset_valid", 32'(bus.rsp_valid_out), 32'd0);
    chk("reset_result", 32'(bus.rsp_result_out), 32'd0);
    reset_in = 1'b0;
    step();

    run_op(2'b00, 32'h0000_0100, "size_100");
    run_op(2'b00, 32'h0000_00FF, "size_ff");
    run_op(2'b00, 32'h0000_0000, "size_0");
    run_op(2'b01, 32'h0001_0000, "clz_10000");
    run_op(2'b10, 32'h0001_0000, "ctz_10000");
    run_op(2'b01, 32'h0000_0000, "clz_0");
    run_op(2'b10, 32'h0000_0000, "ctz_0");
    run_op(2'b11, 32'hFFFF_FFFF, "cpop_ffffffff");
    run_op(2'b11, 32'hA5A5_0001, "cpop_a5a50001");
    run_op(2'b01, 32'h8000_0000, "clz_80000000");

    // Backpressure: hold rsp_ready_in low for five cycles of DONE.
    issue(2'b00, 32'h0000_0100, acc, ok);
    e.acc = acc; e.res = 6'd9; e.lat = ref_lat(32'h0000_0100); e.name = "bp_size";
    exp_q.push_back(e);
    n = 0;
    while (!bus.rsp_valid_out && n < 50) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 32'(bus.rsp_valid_out), 32'd1);
      chk("bp_ready_low", 32'(bus.req_ready_out), 32'd0);
      step();
    end
    wait_drain();

    // A request presented together with kill is refused.
    bus.req_op_in = 2'b11; bus.req_opnd_in = 32'hFFFF_FFFF;
    bus.req_valid_in = 1'b1; bus.kill_in = 1'b1;
    step();
    bus.req_valid_in = 1'b0; bus.kill_in = 1'b0;
    chk("kill_idle_ready", 32'(bus.req_ready_out), 32'd1);

    // Kill during the third SCAN cycle: no response at all.
    issue(2'b11, 32'hFFFF_FFFF, acc, ok);
    step(); step();
    bus.kill_in = 1'b1;
    step();
    bus.kill_in = 1'b0;
    chk("kill_scan_ready", 32'(bus.req_ready_out), 32'd1);
    bus.rsp_ready_in = 1'b1;
    repeat (12) step();
    bus.rsp_ready_in = 1'b0;
    chk("kill_scan_no_valid", 32'(bus.rsp_valid_out), 32'd0);
    run_op(2'b00, 32'h8000_0000, "size_after_kill");

    // Kill in DONE wins over rsp_ready_in.
    issue(2'b10, 32'h0000_0040, acc, ok);
    e.acc = acc; e.res = 6'd6; e.lat = ref_lat(32'h0000_0040); e.name = "kill_done";
    exp_q.push_back(e);
    n = 0;
    while (!bus.rsp_valid_out && n < 50) begin step(); n++; end
    bus.rsp_ready_in = 1'b1; bus.kill_in = 1'b1;
    step();
    bus.rsp_ready_in = 1'b0; bus.kill_in = 1'b0;
    chk("kill_done_valid", 32'(bus.rsp_valid_out), 32'd0);
    chk("kill_done_ready", 32'(bus.req_ready_out), 32'd1);
    chk("kill_done_pending", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_back());

    // Asynchronous reset between edges in the middle of a scan.
    issue(2'b11, 32'h0F0F_0F0F, acc, ok);
    step(); step();
    #1 reset_in = 1'b1;
    #1;
    chk("areset_valid", 32'(bus.rsp_valid_out), 32'd0);
    chk("areset_ready", 32'(bus.req_ready_out), 32'd1);
    chk("areset_result", 32'(bus.rsp_result_out), 32'd0);
    step(); step();
    reset_in = 1'b0;
    step();
    run_op(2'b10, 32'h0000_0008, "ctz_after_reset");

    // Randomized operations with random backpressure and varied operand widths.
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] v;
      v = $urandom() >> $urandom_range(0, 32);
      if ($urandom_range(0, 9) == 0) v = '0;
      run_op(2'($urandom_range(0, 3)), v, "rand");
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
